// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: forwarding, load-use stall, mul/div occupancy FSM.
// Optional macro STALL_CNT_EN adds a 32-bit stall cycle counter output.
module pipe_hazard_ctrl #(
   parameter int MD_LAT = 4,
   parameter int CW     = 4
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       id_md,
   input  logic       id_taken,
   input  logic       ewreg,
   input  logic       em2reg,
   input  logic [4:0] ern,
   input  logic       mwreg,
   input  logic       mm2reg,
   input  logic [4:0] mrn,
   input  logic       mem_busy,
   output logic       wpcir,
   output logic       bubble,
   output logic       flush_ifid,
   output logic       pipe_en,
   output logic [1:0] fwda,
   output logic [1:0] fwdb,
   output logic       md_busy
`ifdef STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   typedef enum logic {RUN, MD_BUSY} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lu;

   function automatic logic [1:0] fwd_sel(
      input logic [4:0] r,
      input logic       ew,
      input logic       el,
      input logic [4:0] en,
      input logic       mw,
      input logic       ml,
      input logic [4:0] mn
   );
      logic [1:0] s;
      s = 2'b00;
      if (ew && !el && en != 5'd0 && en == r)
         s = 2'b01;
      else if (mw && !ml && mn != 5'd0 && mn == r)
         s = 2'b10;
      else if (mw && ml && mn != 5'd0 && mn == r)
         s = 2'b11;
      return s;
   endfunction

   assign lu = ewreg && em2reg && ern != 5'd0 &&
               ((id_use_rs && ern == id_rs) ||
                (id_use_rt && ern == id_rt));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wpcir   = 1'b1;
      bubble  = 1'b0;
      pipe_en = 1'b1;
      md_busy = (state_q == MD_BUSY);
      fwda    = fwd_sel(id_rs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
      fwdb    = fwd_sel(id_rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
      unique case (state_q)
         RUN: begin
            if (lu) begin
               wpcir  = 1'b0;
               bubble = 1'b1;
            end else if (id_md) begin
               state_d = MD_BUSY;
               cnt_d   = CW'(MD_LAT - 1);
            end
         end
         MD_BUSY: begin
            wpcir  = 1'b0;
            bubble = 1'b1;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1))
               state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      // memory wait holds every stage in place, including the FSM
      if (mem_busy) begin
         pipe_en = 1'b0;
         wpcir   = 1'b0;
         bubble  = 1'b0;
         state_d = state_q;
         cnt_d   = cnt_q;
      end
      if (clrn) begin
         wpcir   = 1'b0;
         bubble  = 1'b1;
         pipe_en = 1'b0;
         md_busy = 1'b0;
         fwda    = 2'b00;
         fwdb    = 2'b00;
         state_d = RUN;
         cnt_d   = '0;
      end
      flush_ifid = id_taken && wpcir;
   end

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn)
         stall_q <= '0;
      else if (!wpcir)
         stall_q <= stall_q + 32'd1;
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed
// multi-cycle sequences and randomized stimulus against a reference model.
module tb_pipe_hazard_ctrl;

   localparam int MD_LAT = 4;
   localparam int CW     = 4;

   logic       clk = 1'b0;
   logic       clrn;
   logic [4:0] id_rs, id_rt, ern, mrn;
   logic       id_use_rs, id_use_rt, id_md, id_taken;
   logic       ewreg, em2reg, mwreg, mm2reg, mem_busy;
   logic       wpcir, bubble, flush_ifid, pipe_en, md_busy;
   logic [1:0] fwda, fwdb;
`ifdef STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // reference model state
   int          md_left = 0;
   logic [31:0] m_stall = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CW(CW)) dut (
      .clk(clk), .clrn(clrn),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_md(id_md), .id_taken(id_taken),
      .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
      .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
      .mem_busy(mem_busy),
      .wpcir(wpcir), .bubble(bubble), .flush_ifid(flush_ifid),
      .pipe_en(pipe_en), .fwda(fwda), .fwdb(fwdb), .md_busy(md_busy)
`ifdef STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   typedef struct {
      logic wpcir, bubble, flush, pipe_en, md_busy, lu;
      logic [1:0] fa, fb;
   } exp_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Newest producer of a register wins; loads in EX cannot be forwarded.
   function automatic logic [1:0] m_fwd(input logic [4:0] r);
      logic       w [2];
      logic       ld[2];
      logic [4:0] rn[2];
      w[0] = ewreg; ld[0] = em2reg; rn[0] = ern;
      w[1] = mwreg; ld[1] = mm2reg; rn[1] = mrn;
      if (r == 0) return 2'b00;
      for (int s = 0; s < 2; s++)
         if (w[s] && rn[s] == r) begin
            if (s == 0 && !ld[0]) return 2'b01;
            if (s == 1) return ld[1] ? 2'b11 : 2'b10;
         end
      return 2'b00;
   endfunction

   function automatic exp_t model();
      exp_t e;
      e.lu = ewreg && em2reg && ern != 0 &&
             ((id_use_rs && ern == id_rs) || (id_use_rt && ern == id_rt));
      e.fa = m_fwd(id_rs);
      e.fb = m_fwd(id_rt);
      e.md_busy = md_left > 0;
      e.pipe_en = !mem_busy;
      if (mem_busy) begin
         e.wpcir = 0; e.bubble = 0;
      end else if (md_left > 0 || e.lu) begin
         e.wpcir = 0; e.bubble = 1;
      end else begin
         e.wpcir = 1; e.bubble = 0;
      end
      if (clrn) begin
         e.wpcir = 0; e.bubble = 1; e.pipe_en = 0;
         e.md_busy = 0; e.fa = 0; e.fb = 0;
      end
      e.flush = id_taken && e.wpcir;
      return e;
   endfunction

   task automatic check_model();
      exp_t e;
      e = model();
      chk("ctl", {27'd0, wpcir, bubble, flush_ifid, pipe_en, md_busy},
          {27'd0, e.wpcir, e.bubble, e.flush, e.pipe_en, e.md_busy});
      if (clrn || !e.lu) begin
         chk("fwda", {30'd0, fwda}, {30'd0, e.fa});
         chk("fwdb", {30'd0, fwdb}, {30'd0, e.fb});
      end
`ifdef STALL_CNT_EN
      chk("stall_cnt", stall_cnt, clrn ? 32'd0 : m_stall);
`endif
   endtask

   task automatic update_model();
      exp_t e;
      e = model();
      if (clrn) begin
         md_left = 0;
         m_stall = 0;
      end else begin
         if (!e.wpcir) m_stall++;
         if (!mem_busy) begin
            if (md_left > 0) md_left--;
            else if (id_md && !e.lu) md_left = MD_LAT - 1;
         end
      end
   endtask

   // inputs are set just after a falling edge; compare, then clock
   task automatic cycle();
      #1 check_model();
      @(posedge clk);
      update_model();
      @(negedge clk);
   endtask

   task automatic idle();
      id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
      id_md = 0; id_taken = 0; ewreg = 0; em2reg = 0; ern = 0;
      mwreg = 0; mm2reg = 0; mrn = 0; mem_busy = 0;
   endtask

   typedef struct {
      logic [4:0] rs, rt;
      logic       urs, urt, ew, el;
      logic [4:0] en;
      logic       mw, ml;
      logic [4:0] mn;
      logic [1:0] fa, fb;
      logic       wp, bub, cf;
   } vec_t;

   vec_t vt[10];

   initial begin
      vt[0] = '{5, 0, 1, 0, 1, 0, 5, 1, 0, 5, 2'b01, 2'b00, 1, 0, 1};
      vt[1] = '{5, 0, 1, 0, 1, 0, 0, 1, 0, 5, 2'b10, 2'b00, 1, 0, 1};
      vt[2] = '{5, 0, 1, 0, 1, 0, 0, 1, 1, 5, 2'b11, 2'b00, 1, 0, 1};
      vt[3] = '{0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1, 0, 1};
      vt[4] = '{1, 7, 1, 1, 1, 0, 7, 0, 0, 7, 2'b00, 2'b01, 1, 0, 1};
      vt[5] = '{0, 8, 0, 1, 1, 1, 8, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0};
      vt[6] = '{0, 8, 0, 0, 1, 1, 8, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1};
      vt[7] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1};
      vt[8] = '{3, 0, 0, 0, 1, 1, 3, 1, 0, 3, 2'b10, 2'b00, 1, 0, 1};
      vt[9] = '{3, 3, 1, 1, 0, 0, 3, 0, 1, 3, 2'b00, 2'b00, 1, 0, 1};

      idle();
      clrn = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_ctl", {27'd0, wpcir, bubble, flush_ifid, pipe_en, md_busy},
          32'b01000);
      chk("rst_fwd", {28'd0, fwda, fwdb}, 32'd0);
      check_model();
      @(negedge clk);
      clrn = 0;

      foreach (vt[i]) begin
         id_rs = vt[i].rs; id_rt = vt[i].rt;
         id_use_rs = vt[i].urs; id_use_rt = vt[i].urt;
         ewreg = vt[i].ew; em2reg = vt[i].el; ern = vt[i].en;
         mwreg = vt[i].mw; mm2reg = vt[i].ml; mrn = vt[i].mn;
         #1;
         chk($sformatf("vec%0d_stall", i), {30'd0, wpcir, bubble},
             {30'd0, vt[i].wp, vt[i].bub});
         if (vt[i].cf)
            chk($sformatf("vec%0d_fwd", i), {28'd0, fwda, fwdb},
                {28'd0, vt[i].fa, vt[i].fb});
         cycle();
      end

      // load-use lasts one cycle; a taken branch is only flushed once ID moves
      idle();
      ewreg = 1; em2reg = 1; ern = 8; id_rt = 8; id_use_rt = 1;
      id_taken = 1;
      #1 chk("lu_hold", {29'd0, wpcir, bubble, flush_ifid}, 32'b010);
      cycle();
      ewreg = 0; em2reg = 0;
      #1 chk("lu_release", {29'd0, wpcir, bubble, flush_ifid}, 32'b101);
      cycle();

      // plain mul/div: three frozen cycles after issue
      idle();
      id_md = 1;
      #1 chk("md_issue", {30'd0, wpcir, md_busy}, 32'b10);
      cycle();
      id_md = 0;
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("md_busy%0d", k), {29'd0, md_busy, wpcir, bubble},
                32'b101);
         cycle();
      end
      #1 chk("md_done", {30'd0, md_busy, wpcir}, 32'b01);
      cycle();

      // memory wait in the middle of a mul/div
      id_md = 1;
      cycle();
      id_md = 0;
      cycle();
      mem_busy = 1;
      for (int k = 0; k < 2; k++) begin
         #1 chk($sformatf("mb_hold%0d", k),
                {28'd0, pipe_en, bubble, wpcir, md_busy}, 32'b0001);
         cycle();
      end
      mem_busy = 0;
      for (int k = 0; k < 2; k++) begin
         #1 chk($sformatf("mb_after%0d", k), {30'd0, md_busy, wpcir}, 32'b10);
         cycle();
      end
      #1 chk("mb_done", {30'd0, md_busy, wpcir}, 32'b01);
      cycle();

      // reset in the middle of a mul/div
      id_md = 1;
      cycle();
      id_md = 0;
      cycle();
      clrn = 1;
      #1 chk("rst_md", {29'd0, md_busy, wpcir, bubble}, 32'b001);
      cycle();
      clrn = 0;
      #1 chk("rst_md_rel", {30'd0, md_busy, wpcir}, 32'b01);
      cycle();

      for (int n = 0; n < 3000; n++) begin
         id_rs = 5'($urandom_range(0, 3));
         id_rt = 5'($urandom_range(0, 3));
         ern = 5'($urandom_range(0, 3));
         mrn = 5'($urandom_range(0, 3));
         {id_use_rs, id_use_rt, ewreg, em2reg, mwreg, mm2reg, id_taken} =
            7'($urandom);
         id_md = ($urandom_range(0, 7) == 0);
         mem_busy = ($urandom_range(0, 4) == 0);
         clrn = ($urandom_range(0, 63) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It computes operand-forwarding selects for ID, detects load-use hazards, and sequences multi-cycle multiply/divide occupancy of EX with a counter-based FSM. It also applies external memory-wait freezes and branch flushes. Its outputs drive the write enables and clears of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
MD_LAT, 4, total EX-occupancy cycles of a multi-cycle mul/div op (legal range 2..16)
CW, 4, width of the MD countdown counter (must satisfy 2^CW > MD_LAT)

Ports:
clk  in  1  pipeline clock
clrn  in  1  asynchronous reset, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_md  in  1  ID instruction is multi-cycle mul/div
id_taken  in  1  branch/jump resolved taken in ID
ewreg  in  1  EX-stage instruction writes register file
em2reg  in  1  EX-stage instruction is a load
ern  in  5  EX-stage destination register
mwreg  in  1  MEM-stage instruction writes register file
mm2reg  in  1  MEM-stage instruction is a load
mrn  in  5  MEM-stage destination register
mem_busy  in  1  data memory not ready; freeze entire pipe
wpcir  out  1  PC and IF/ID write enable (0 = hold)
bubble  out  1  clear ID/EX controls (insert NOP)
flush_ifid  out  1  clear IF/ID instruction
pipe_en  out  1  EX/MEM and MEM/WB write enable
fwda  out  2  rs operand select: 00 regfile, 01 EX alu, 10 MEM alu, 11 MEM load data
fwdb  out  2  rt operand select, same encoding
md_busy  out  1  FSM in MD_BUSY

Behaviour:
- While clrn=1: state=RUN, counter=0, md_busy=0. Forced outputs: wpcir=0, bubble=1, flush_ifid=0, pipe_en=0, fwda=fwdb=00.
- Forwarding is combinational for each of rs/rt. Register r0 is never forwarded.
- Forwarding priority:
  - 01 if ewreg & !em2reg & ern!=0 & ern==reg.
  - else 10 if mwreg & !mm2reg & mrn!=0 & mrn==reg.
  - else 11 if mwreg & mm2reg & mrn!=0 & mrn==reg.
  - else 00.
- Load-use hazard, lu = ewreg & em2reg & ern!=0 & ((id_use_rs & ern==id_rs) | (id_use_rt & ern==id_rt)). Forwarding selects are don't-care while lu=1.
- FSM states are RUN and MD_BUSY. Counter is CW bits wide.
- RUN:
  - lu=1: wpcir=0, bubble=1, one-cycle stall; re-evaluated each cycle.
  - id_md=1 & lu=0 & mem_busy=0: the MD op advances into EX. At the clock edge, go to MD_BUSY with counter=MD_LAT-1.
  - Otherwise wpcir=1, bubble=0.
- MD_BUSY:
  - md_busy=1, wpcir=0, bubble=1.
  - Counter decrements each enabled cycle.
  - When counter==1 and the cycle is enabled, go to RUN at the clock edge.
  - Total freeze of PC and IF/ID is MD_LAT-1 cycles after issue.
- flush_ifid = id_taken & wpcir. A flush is suppressed whenever ID is held (lu, MD_BUSY, mem_busy); the branch re-resolves later.
- mem_busy=1 has highest priority:
  - pipe_en=0, wpcir=0, bubble=0 (hold, not bubble), flush_ifid=0.
  - FSM and counter are frozen. No MD issue.
- pipe_en=1 whenever clrn=0 and mem_busy=0.
- Simultaneous id_md and lu: the stall wins and MD issue is deferred.
- Reset during MD_BUSY: immediate return to RUN with counter=0.

Optional Feature:
- Macro STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0], reset to 0.
  - Increments on every cycle with clrn=0 and wpcir=0.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Forwarding: ern=5, ewreg=1, em2reg=0, mrn=5, mwreg=1, id_rs=5 -> fwda=01 (EX priority). Set ern=0 -> fwda=10. Set mm2reg=1 -> fwda=11. Set id_rs=0 -> fwda=00.
- Load-use: ewreg=1, em2reg=1, ern=8, id_rt=8, id_use_rt=1 -> exactly one cycle wpcir=0, bubble=1. Next cycle (EX cleared) wpcir=1.
- MD with MD_LAT=4: id_md=1 for one cycle -> md_busy=1, wpcir=0 for 3 cycles, then RUN, wpcir=1. With STALL_CNT_EN, stall_cnt=3.
- mem_busy=1 for 2 cycles mid MD_BUSY (counter=2) -> pipe_en=0, bubble=0, counter holds 2. After release, 2 more busy cycles.
- id_taken=1 with lu=1 -> flush_ifid=0. Next cycle lu=0, id_taken=1 -> flush_ifid=1.
- Assert clrn=1 while MD_BUSY counter=2 -> md_busy=0, wpcir=0, bubble=1 immediately. After release, RUN with wpcir=1.
